fetch_ctrl_fsm: RTL and testbench
=================================

# fetch_ctrl_fsm

Control and execute stage directly downstream of the program counter / program ROM / instruction register fetch path. Consumes the 12-bit instruction held in the instruction register and sequences the fetch path by driving ROM output enable, IR load, PC increment and PC jump-load. Executes a 3-bit-opcode instruction set on an internal 8-bit accumulator. Presents results through a valid/ready output port.

## Interface
- `ACC_W`, 8: accumulator and output data width.
- `PC_W`, 9: program address width; matches the PC register and ROM address.
- `IR_W`, 12: instruction width; `[11:9]` opcode, `[8:0]` operand.

Ports:
- `CLK`, in, 1: single clock. All state changes on the rising edge.
- `RST`, in, 1: asynchronous, active-high reset.
- `ir_in`, in, `IR_W`: instruction register contents.
- `rom_oe`, out, 1: program ROM output enable.
- `ir_load`, out, 1: instruction register load enable.
- `pc_inc`, out, 1: PC enable with the mux selecting PC+1.
- `pc_jump`, out, 1: PC enable with the mux selecting the IR operand.
- `pc_target`, out, `PC_W`: jump target, equal to `ir_in[8:0]`.
- `out_data`, out, `ACC_W`: accumulator snapshot taken by OUT.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: consumer accepts the data.
- `acc`, out, `ACC_W`: accumulator (debug).
- `zero`, out, 1: zero flag.
- `halted`, out, 1: high while in HALT.
- `step_req`, in, 1: single-step request. Present only with `FETCH_CTRL_STEP_EN`.

## Operation
- Opcodes:
  - 000 NOP
  - 001 LDI: `acc <= op[7:0]`
  - 010 ADD: `acc <= acc + op[7:0]`
  - 011 SUB: `acc <= acc - op[7:0]`
  - 100 JMP
  - 101 JZ: jump if `zero`
  - 110 OUT
  - 111 HLT
- Arithmetic is modulo 2^8, and carry is discarded. `op[8]` is ignored for ALU ops.
- `zero` is updated by LDI, ADD and SUB only: `zero = (result == 0)`.
- FSM states:
  - FETCH: `rom_oe=1`. Next state is LOAD.
  - LOAD: `rom_oe=1`, `ir_load=1`; the IR captures at the end of this cycle. Next state is EXEC.
  - EXEC: decode `ir_in`.
    - ALU op, NOP, or JZ not taken: `pc_inc=1`, then FETCH.
    - JMP, or JZ taken: `pc_jump=1`, then FETCH.
    - OUT: snapshot acc into `out_data`, set `out_valid`, then OWAIT.
    - HLT: go to HALT with no PC pulse.
  - OWAIT: hold `out_valid`. When `out_valid && out_ready`, pulse `pc_inc` and go to FETCH; otherwise stay.
  - HALT: terminal until reset. All strobes stay 0.
- `out_data` is stable while `out_valid` is high. `out_valid` deasserts in the cycle after acceptance.
- `pc_inc` and `pc_jump` are never high together.

## Timing
- Reset values:
  - state FETCH
  - `acc` 0, `zero` 0
  - `out_data` 0, `out_valid` 0
  - `halted` 0
  - all strobes 0
- Strobes are Moore outputs decoded from state, except that `pc_inc` in OWAIT is gated by `out_ready`.
- Latency: 3 cycles per non-OUT instruction. OUT takes 3 cycles plus the ready wait, and the minimum is 4 cycles (OWAIT is always visited).
- The ROM has a full FETCH cycle plus the LOAD cycle to settle before IR capture.
- The accumulator and flags update at the end of EXEC.
- `RST` mid-instruction or mid-handshake forces the reset values immediately: `out_valid` drops and no PC pulse is issued. The PC register's own reset is driven separately.
- `out_ready` high before `out_valid` has no effect.

## Configuration
- `FETCH_CTRL_STEP_EN` defined:
  - The `step_req` port exists.
  - FETCH holds with all strobes 0 until a rising edge of `step_req`, detected through an internal registered copy.
  - One edge advances exactly one instruction.
- `FETCH_CTRL_STEP_EN` undefined: no port, and FETCH always advances.

## Structure
- Package `fetch_ctrl_pkg` contains:
  - opcode localparams `OP_NOP` through `OP_HLT`
  - state enum `ctrl_state_t`
  - field slices `OPC_MSB`/`OPC_LSB`
- One sub-module, `ctrl_alu`, is combinational: inputs `a`, `b`, `sub`; outputs `y` and `z`. It is instantiated once.

## Test plan
- Reset, then program `LDI 5; ADD 3; OUT` with `out_ready=1` → `out_data=8`, `out_valid` high for exactly 1 cycle, PC sequence 0,1,2,3.
- `LDI 1; SUB 1; JZ 0x040` → `zero=1`, `pc_jump` pulse with `pc_target=0x040`, no `pc_inc` in that EXEC.
- `LDI 0xFF; ADD 2` → `acc=0x01`, `zero=0` (wrap). `LDI 0; SUB 1` → `acc=0xFF`.
- OUT with `out_ready` low for 5 cycles → `out_valid` and `out_data` held stable, no PC pulse. Raising ready gives one `pc_inc`.
- HLT → `halted=1`, no further strobes over 20 cycles. Asserting `RST` mid-OWAIT → `out_valid=0` immediately and state FETCH.
- With `FETCH_CTRL_STEP_EN`: no `step_req` for 10 cycles → no strobes. One edge → exactly one instruction executes.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, opcodes and FSM state type for the fetch/execute controller.
package fetch_ctrl_pkg;

  localparam int unsigned ACC_W   = 8;
  localparam int unsigned PC_W    = 9;
  localparam int unsigned IR_W    = 12;
  localparam int unsigned OPC_MSB = 11;
  localparam int unsigned OPC_LSB = 9;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_OUT = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_LOAD,
    ST_EXEC,
    ST_OWAIT,
    ST_HALT
  } ctrl_state_t;

  function automatic logic [2:0] opcode_of(input logic [IR_W-1:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_ctrl_fsm_if.sv
// Fetch-path strobes, instruction input and valid/ready result port of the controller.
// step_req exists only when FETCH_CTRL_STEP_EN is defined.
interface fetch_ctrl_fsm_if;
  import fetch_ctrl_pkg::*;

  logic [IR_W-1:0]  ir_in;
  logic             rom_oe;
  logic             ir_load;
  logic             pc_inc;
  logic             pc_jump;
  logic [PC_W-1:0]  pc_target;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc;
  logic             zero;
  logic             halted;
`ifdef FETCH_CTRL_STEP_EN
  logic             step_req;
`endif

  modport master (
`ifdef FETCH_CTRL_STEP_EN
    input  step_req,
`endif
    input  ir_in, out_ready,
    output rom_oe, ir_load, pc_inc, pc_jump, pc_target,
    output out_data, out_valid, acc, zero, halted
  );

  modport slave (
`ifdef FETCH_CTRL_STEP_EN
    output step_req,
`endif
    output ir_in, out_ready,
    input  rom_oe, ir_load, pc_inc, pc_jump, pc_target,
    input  out_data, out_valid, acc, zero, halted
  );

endinterface

// File: rtl/ctrl_alu.sv
// Combinational 8-bit add/subtract with zero detect; carry is dropped.
module ctrl_alu
  import fetch_ctrl_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             sub,
  output logic [ACC_W-1:0] y,
  output logic             z
);

  assign y = sub ? (a - b) : (a + b);
  assign z = (y == ACC_W'(0));

endmodule

// File: rtl/fetch_ctrl_fsm.sv
// Fetch/execute controller: sequences ROM/IR/PC and runs the accumulator ISA.
// Optional single-step gating of FETCH under FETCH_CTRL_STEP_EN.
module fetch_ctrl_fsm
  import fetch_ctrl_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  fetch_ctrl_fsm_if.master bus
);

  ctrl_state_t      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             zero_q, zero_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic             rom_oe_s, ir_load_s, pc_inc_s, pc_jump_s;
  logic             step_go;
  logic [2:0]       opc;
  logic [ACC_W-1:0] alu_a, alu_y;
  logic             alu_sub, alu_z;

  assign opc     = opcode_of(bus.ir_in);
  // LDI reuses the adder with a zero left operand
  assign alu_a   = (opc == OP_LDI) ? ACC_W'(0) : acc_q;
  assign alu_sub = (opc == OP_SUB);

  ctrl_alu u_alu (
    .a   (alu_a),
    .b   (bus.ir_in[ACC_W-1:0]),
    .sub (alu_sub),
    .y   (alu_y),
    .z   (alu_z)
  );

`ifdef FETCH_CTRL_STEP_EN
  logic step_q, step_pend_q, step_pend_d, step_edge;

  // An edge seen outside FETCH is held until FETCH consumes it
  assign step_edge   = bus.step_req & ~step_q;
  assign step_go     = step_pend_q | step_edge;
  assign step_pend_d = step_go & (state_q != ST_FETCH);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      step_q      <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      step_q      <= bus.step_req;
      step_pend_q <= step_pend_d;
    end
  end
`else
  assign step_go = 1'b1;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_FETCH;
      acc_q       <= '0;
      zero_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      zero_q      <= zero_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    zero_d      = zero_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rom_oe_s    = 1'b0;
    ir_load_s   = 1'b0;
    pc_inc_s    = 1'b0;
    pc_jump_s   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (step_go) begin
          rom_oe_s = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        rom_oe_s  = 1'b1;
        ir_load_s = 1'b1;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (opc)
          OP_LDI, OP_ADD, OP_SUB: begin
            acc_d    = alu_y;
            zero_d   = alu_z;
            pc_inc_s = 1'b1;
          end
          OP_JMP: pc_jump_s = 1'b1;
          OP_JZ: begin
            pc_jump_s = zero_q;
            pc_inc_s  = ~zero_q;
          end
          OP_OUT: begin
            out_data_d  = acc_q;
            out_valid_d = 1'b1;
            state_d     = ST_OWAIT;
          end
          OP_HLT: state_d = ST_HALT;
          default: pc_inc_s = 1'b1;
        endcase
      end
      ST_OWAIT: begin
        if (out_valid_q && bus.out_ready) begin
          pc_inc_s    = 1'b1;
          out_valid_d = 1'b0;
          state_d     = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Strobes forced low while reset is asserted, even though state reads FETCH
  assign bus.rom_oe    = rom_oe_s  & ~RST;
  assign bus.ir_load   = ir_load_s & ~RST;
  assign bus.pc_inc    = pc_inc_s  & ~RST;
  assign bus.pc_jump   = pc_jump_s & ~RST;
  assign bus.pc_target = bus.ir_in[PC_W-1:0];
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc       = acc_q;
  assign bus.zero      = zero_q;
  assign bus.halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_ctrl_fsm.sv
// Directed bench for fetch_ctrl_fsm with a behavioural PC/ROM/IR fetch path.
module tb_fetch_ctrl_fsm;
  import fetch_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  fetch_ctrl_fsm_if bus();

  fetch_ctrl_fsm dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  logic [11:0] rom [0:511];
  logic [8:0]  pc;
  logic [11:0] ir;

  assign bus.ir_in = ir;

  // Fetch path: PC register, ROM and IR
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (bus.pc_jump)     pc <= bus.pc_target;
      else if (bus.pc_inc) pc <= pc + 9'd1;
      if (bus.ir_load)     ir <= rom[pc];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc, n_valid, n_inc, n_jump, n_both, n_strobe, n_instab;
  logic [8:0] last_jump_tgt;
  logic [8:0] last_pc;
  logic [8:0] pc_hist [$];
  logic       prev_valid;
  logic [7:0] prev_data;

  always @(negedge CLK) begin
    if (RST) begin
      cyc = 0; n_valid = 0; n_inc = 0; n_jump = 0; n_both = 0;
      n_strobe = 0; n_instab = 0; last_jump_tgt = '0; last_pc = '0;
      prev_valid = 1'b0; prev_data = '0;
      pc_hist.delete();
    end else begin
      cyc++;
      if (bus.out_valid) n_valid++;
      if (prev_valid && bus.out_valid && bus.out_data != prev_data) n_instab++;
      prev_valid = bus.out_valid;
      prev_data  = bus.out_data;
      if (bus.pc_inc) n_inc++;
      if (bus.pc_jump) begin
        n_jump++;
        last_jump_tgt = bus.pc_target;
      end
      if (bus.pc_inc && bus.pc_jump) n_both++;
      if (bus.rom_oe || bus.ir_load || bus.pc_inc || bus.pc_jump) n_strobe++;
      if (pc != last_pc) begin
        pc_hist.push_back(pc);
        last_pc = pc;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ins(input logic [2:0] op, input logic [8:0] arg);
    return {op, arg};
  endfunction

  task automatic rom_fill();
    for (int i = 0; i < 512; i++) rom[i] = ins(OP_HLT, 9'd0);
  endtask

  task automatic rst_on();
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK); #2;
  endtask

  task automatic run_until_halt(input string tag, input int budget, output int at_cyc);
    for (int i = 0; i < budget; i++) begin
      settle();
      if (bus.halted) break;
    end
    at_cyc = cyc;
    check_eq({tag, "_halted"}, 32'(bus.halted), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      settle();
      if (bus.out_valid) break;
    end
    check_eq({tag, "_valid_seen"}, 32'(bus.out_valid), 32'd1);
  endtask

  int hc;
  int snap;

  initial begin
    bus.out_ready = 1'b1;
`ifdef FETCH_CTRL_STEP_EN
    bus.step_req = 1'b0;
`endif
    rom_fill();
    rom[0] = ins(OP_LDI, 9'd5);
    rom[1] = ins(OP_ADD, 9'd3);
    rom[2] = ins(OP_OUT, 9'd0);
    rom[3] = ins(OP_HLT, 9'd0);
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_strobes", 32'({bus.rom_oe, bus.ir_load, bus.pc_inc, bus.pc_jump}), 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
    check_eq("rst_acc", 32'(bus.acc), 32'd0);
    check_eq("rst_zero", 32'(bus.zero), 32'd0);
    check_eq("rst_halted", 32'(bus.halted), 32'd0);

`ifdef FETCH_CTRL_STEP_EN
    rom[0] = ins(OP_LDI, 9'd7);
    rom[1] = ins(OP_LDI, 9'd9);
    RST = 1'b0;
    repeat (10) settle();
    check_eq("step_idle_strobes", 32'(n_strobe), 32'd0);
    @(posedge CLK); #1;
    bus.step_req = 1'b1;
    repeat (15) settle();
    check_eq("step1_acc", 32'(bus.acc), 32'd7);
    check_eq("step1_pc", 32'(pc), 32'd1);
    check_eq("step1_inc", 32'(n_inc), 32'd1);
    @(posedge CLK); #1;
    bus.step_req = 1'b0;
    repeat (3) settle();
    @(posedge CLK); #1;
    bus.step_req = 1'b1;
    repeat (15) settle();
    check_eq("step2_acc", 32'(bus.acc), 32'd9);
    check_eq("step2_pc", 32'(pc), 32'd2);
`else
    // LDI 5; ADD 3; OUT; HLT with ready held high
    RST = 1'b0;
    settle();
    check_eq("t1_fetch_rom_oe", 32'(bus.rom_oe), 32'd1);
    check_eq("t1_fetch_ir_load", 32'(bus.ir_load), 32'd0);
    run_until_halt("t1", 40, hc);
    check_eq("t1_halt_cycle", 32'(hc), 32'd14);
    check_eq("t1_out_data", 32'(bus.out_data), 32'd8);
    check_eq("t1_valid_cycles", 32'(n_valid), 32'd1);
    check_eq("t1_pc_hist_len", 32'(pc_hist.size()), 32'd3);
    check_eq("t1_pc_hist0", 32'(pc_hist[0]), 32'd1);
    check_eq("t1_pc_hist1", 32'(pc_hist[1]), 32'd2);
    check_eq("t1_pc_hist2", 32'(pc_hist[2]), 32'd3);
    snap = n_strobe;
    repeat (20) settle();
    check_eq("t1_halt_quiet", 32'(n_strobe), 32'(snap));
    check_eq("t1_still_halted", 32'(bus.halted), 32'd1);

    // LDI 1; SUB 1; JZ 0x040 -> taken
    rst_on();
    rom_fill();
    rom[0] = ins(OP_LDI, 9'd1);
    rom[1] = ins(OP_SUB, 9'd1);
    rom[2] = ins(OP_JZ, 9'h040);
    rom[3] = ins(OP_LDI, 9'd77);
    RST = 1'b0;
    run_until_halt("t2", 40, hc);
    check_eq("t2_halt_cycle", 32'(hc), 32'd13);
    check_eq("t2_zero", 32'(bus.zero), 32'd1);
    check_eq("t2_acc", 32'(bus.acc), 32'd0);
    check_eq("t2_jumps", 32'(n_jump), 32'd1);
    check_eq("t2_jump_target", 32'(last_jump_tgt), 32'h040);
    check_eq("t2_incs", 32'(n_inc), 32'd2);
    check_eq("t2_both", 32'(n_both), 32'd0);
    check_eq("t2_pc", 32'(pc), 32'h040);

    // LDI 0xFF; ADD 2 -> wraps to 1
    rst_on();
    rom_fill();
    rom[0] = ins(OP_LDI, 9'h0FF);
    rom[1] = ins(OP_ADD, 9'd2);
    RST = 1'b0;
    run_until_halt("t3a", 40, hc);
    check_eq("t3a_acc", 32'(bus.acc), 32'h01);
    check_eq("t3a_zero", 32'(bus.zero), 32'd0);

    // LDI 0; SUB 1 -> 0xFF; JZ not taken
    rst_on();
    rom_fill();
    rom[0] = ins(OP_LDI, 9'd0);
    rom[1] = ins(OP_SUB, 9'd1);
    rom[2] = ins(OP_JZ, 9'h050);
    RST = 1'b0;
    run_until_halt("t3b", 40, hc);
    check_eq("t3b_acc", 32'(bus.acc), 32'hFF);
    check_eq("t3b_zero", 32'(bus.zero), 32'd0);
    check_eq("t3b_no_jump", 32'(n_jump), 32'd0);
    check_eq("t3b_pc", 32'(pc), 32'd3);

    // op[8] ignored: LDI 0x1F0 -> 0xF0; ADD 0x110 -> 0x00, zero set
    rst_on();
    rom_fill();
    rom[0] = ins(OP_LDI, 9'h1F0);
    rom[1] = ins(OP_ADD, 9'h110);
    RST = 1'b0;
    run_until_halt("t3c", 40, hc);
    check_eq("t3c_acc", 32'(bus.acc), 32'h00);
    check_eq("t3c_zero", 32'(bus.zero), 32'd1);

    // OUT with ready held low for several cycles
    rst_on();
    rom_fill();
    rom[0] = ins(OP_LDI, 9'h02A);
    rom[1] = ins(OP_OUT, 9'd0);
    bus.out_ready = 1'b0;
    RST = 1'b0;
    wait_valid("t4", 20);
    repeat (5) settle();
    check_eq("t4_hold_valid", 32'(bus.out_valid), 32'd1);
    check_eq("t4_hold_data", 32'(bus.out_data), 32'h2A);
    check_eq("t4_hold_no_inc", 32'(n_inc), 32'd1);
    check_eq("t4_hold_pc", 32'(pc), 32'd1);
    @(posedge CLK); #1;
    bus.out_ready = 1'b1;
    settle();
    check_eq("t4_accept_inc", 32'(bus.pc_inc), 32'd1);
    settle();
    check_eq("t4_valid_drop", 32'(bus.out_valid), 32'd0);
    run_until_halt("t4", 20, hc);
    check_eq("t4_pc", 32'(pc), 32'd2);
    check_eq("t4_incs", 32'(n_inc), 32'd2);
    check_eq("t4_valid_cycles", 32'(n_valid), 32'd7);
    check_eq("t4_stable", 32'(n_instab), 32'd0);

    // HLT at address 0
    rst_on();
    rom_fill();
    RST = 1'b0;
    run_until_halt("t5", 20, hc);
    check_eq("t5_halt_cycle", 32'(hc), 32'd4);
    check_eq("t5_strobes", 32'(n_strobe), 32'd2);
    check_eq("t5_pc", 32'(pc), 32'd0);

    // Reset asserted mid-OWAIT
    rst_on();
    rom_fill();
    rom[0] = ins(OP_LDI, 9'd9);
    rom[1] = ins(OP_OUT, 9'd0);
    bus.out_ready = 1'b0;
    RST = 1'b0;
    wait_valid("t6", 20);
    RST = 1'b1;
    #1;
    check_eq("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("t6_rst_strobes", 32'({bus.rom_oe, bus.ir_load, bus.pc_inc, bus.pc_jump}), 32'd0);
    check_eq("t6_rst_acc", 32'(bus.acc), 32'd0);
    check_eq("t6_rst_data", 32'(bus.out_data), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    settle();
    check_eq("t6_fetch_rom_oe", 32'(bus.rom_oe), 32'd1);
    check_eq("t6_fetch_ir_load", 32'(bus.ir_load), 32'd0);
    check_eq("t6_pc", 32'(pc), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
